// File: rtl/clk_edge_meter_pkg.sv
// Shared constants and helpers for the slow-clock edge meter.
package clk_edge_meter_pkg;

  localparam int unsigned DEF_CNT_W   = 16;
  localparam int unsigned DEF_TIMEOUT = 50000;

  localparam int unsigned MEAS_W = 2;
  typedef logic [MEAS_W-1:0] meas_t;
  localparam meas_t MEAS_SAT = meas_t'(2);

  // Edge count since the last reset or stall, saturating at MEAS_SAT.
  function automatic meas_t meas_inc(input meas_t m);
    return (m >= MEAS_SAT) ? MEAS_SAT : meas_t'(m + meas_t'(1));
  endfunction

endpackage

// File: rtl/clk_edge_meter_sync_edge_detect.sv
// Synchroniser chain for an asynchronous slow input, plus registered
// rise/fall ticks and a same-cycle edge strobe for the measurement logic.
module clk_edge_meter_sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic slow_i,
  output logic slow_sync_o,
  output logic rise_o,
  output logic fall_o,
  output logic edge_c
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   last_c;

  assign last_c = sync_q[SYNC_STAGES-1];
  assign edge_c = last_c ^ prev_q;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], slow_i};
    rise_d = edge_c & last_c;
    fall_d = edge_c & ~last_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= last_c;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign slow_sync_o = last_c;
  assign rise_o      = rise_q;
  assign fall_o      = fall_q;

endmodule

// File: rtl/clk_edge_meter.sv
// Turns a slow toggling input into system-clock enables, measures its
// half-period in clk cycles and flags when it stops toggling.
module clk_edge_meter
  import clk_edge_meter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             slow_in,
  output logic             slow_sync,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             stalled
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic             edge_c;
  logic             stall_hit_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  meas_t            meas_q, meas_d;
  logic             stalled_q, stalled_d;
  logic             valid_q, valid_d;

  clk_edge_meter_sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk         (clk),
    .reset       (reset),
    .slow_i      (slow_in),
    .slow_sync_o (slow_sync),
    .rise_o      (rise_tick),
    .fall_o      (fall_tick),
    .edge_c      (edge_c)
  );

  // An edge on the saturation cycle takes priority over the stall.
  assign stall_hit_c = ~edge_c && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d     = cnt_q;
    half_d    = half_q;
    meas_d    = meas_q;
    stalled_d = stalled_q;
    if (edge_c) begin
      cnt_d     = CNT_W'(1);
      half_d    = cnt_q;
      meas_d    = meas_inc(meas_q);
      stalled_d = 1'b0;
    end else if (stall_hit_c) begin
      meas_d    = '0;
      stalled_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    valid_d = (meas_d == MEAS_SAT) && ~stalled_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      half_q    <= '0;
      meas_q    <= '0;
      stalled_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      meas_q    <= meas_d;
      stalled_q <= stalled_d;
      valid_q   <= valid_d;
    end
  end

  assign half_period  = half_q;
  assign period_valid = valid_q;
  assign stalled      = stalled_q;

endmodule

// File: tb/tb_clk_edge_meter.sv
// Directed bench for clk_edge_meter: instance a uses TIMEOUT=20,
// instance b uses CNT_W=8, TIMEOUT=200; both see the same stimulus.
module tb_clk_edge_meter;

  logic        clk = 1'b0;
  logic        reset;
  logic        slow_in;
  logic        a_sync, a_rise, a_fall, a_valid, a_stalled;
  logic [15:0] a_half;
  logic        b_sync, b_rise, b_fall, b_valid, b_stalled;
  logic [7:0]  b_half;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  clk_edge_meter #(.SYNC_STAGES(2), .CNT_W(16), .TIMEOUT(20)) u_a (
    .clk(clk), .reset(reset), .slow_in(slow_in), .slow_sync(a_sync),
    .rise_tick(a_rise), .fall_tick(a_fall), .half_period(a_half),
    .period_valid(a_valid), .stalled(a_stalled)
  );

  clk_edge_meter #(.SYNC_STAGES(2), .CNT_W(8), .TIMEOUT(200)) u_b (
    .clk(clk), .reset(reset), .slow_in(slow_in), .slow_sync(b_sync),
    .rise_tick(b_rise), .fall_tick(b_fall), .half_period(b_half),
    .period_valid(b_valid), .stalled(b_stalled)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at "cycle 0": just after the last reset edge.
  task automatic apply_reset();
    reset   = 1'b1;
    slow_in = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      n_vec++;
      if ({a_sync, a_rise, a_fall, a_valid, a_stalled} !== 5'b0 || a_half !== 16'd0) begin
        n_err++;
        $display("FAIL reset_idle_a cyc %0d got sync/rise/fall/valid/stall=%b half=%0d exp all 0",
                 i, {a_sync, a_rise, a_fall, a_valid, a_stalled}, a_half);
      end
      n_vec++;
      if ({b_sync, b_rise, b_fall, b_valid, b_stalled} !== 5'b0 || b_half !== 8'd0) begin
        n_err++;
        $display("FAIL reset_idle_b cyc %0d got flags=%b half=%0d exp all 0",
                 i, {b_sync, b_rise, b_fall, b_valid, b_stalled}, b_half);
      end
      step();
    end
  endtask

  task automatic test_toggle4();
    int          m;
    logic        exp_rise, exp_fall, exp_valid, exp_sync;
    logic [15:0] exp_half;
    apply_reset();
    for (int i = 0; i <= 30; i++) begin
      exp_rise = 1'b0;
      exp_fall = 1'b0;
      if (i >= 3 && (i - 3) % 4 == 0) begin
        if (((i - 3) / 4) % 2 == 0) exp_rise = 1'b1;
        else                        exp_fall = 1'b1;
      end
      m         = (i >= 3) ? (i - 3) / 4 + 1 : 0;
      exp_half  = (m == 0) ? 16'd0 : (m == 1) ? 16'd2 : 16'd4;
      exp_valid = (m >= 2);
      exp_sync  = (i >= 2) && (((i - 2) / 4) % 2 == 0);
      n_vec++;
      if (a_rise !== exp_rise || a_fall !== exp_fall) begin
        n_err++;
        $display("FAIL toggle_ticks cyc %0d got rise=%b fall=%b exp rise=%b fall=%b",
                 i, a_rise, a_fall, exp_rise, exp_fall);
      end
      n_vec++;
      if (a_half !== exp_half || a_valid !== exp_valid) begin
        n_err++;
        $display("FAIL toggle_meas cyc %0d got half=%0d valid=%b exp half=%0d valid=%b",
                 i, a_half, a_valid, exp_half, exp_valid);
      end
      n_vec++;
      if (a_sync !== exp_sync || a_stalled !== 1'b0) begin
        n_err++;
        $display("FAIL toggle_sync cyc %0d got sync=%b stalled=%b exp sync=%b stalled=0",
                 i, a_sync, a_stalled, exp_sync);
      end
      slow_in = ((i / 4) % 2 == 0);
      step();
    end
  endtask

  task automatic test_stall_resume();
    logic lvl = 1'b0;
    apply_reset();
    for (int i = 0; i <= 55; i++) begin
      case (i)
        18, 37: begin
          n_vec++;
          if (a_stalled !== 1'b0 || a_valid !== 1'b1 || a_half !== 16'd5) begin
            n_err++;
            $display("FAIL pre_stall cyc %0d got stalled=%b valid=%b half=%0d exp 0/1/5",
                     i, a_stalled, a_valid, a_half);
          end
        end
        38, 39, 42: begin
          n_vec++;
          if (a_stalled !== 1'b1 || a_valid !== 1'b0 || a_half !== 16'd5) begin
            n_err++;
            $display("FAIL stall_set cyc %0d got stalled=%b valid=%b half=%0d exp 1/0/5",
                     i, a_stalled, a_valid, a_half);
          end
        end
        43: begin
          n_vec++;
          if (a_stalled !== 1'b0 || a_rise !== 1'b1 || a_valid !== 1'b0 || a_half !== 16'd20) begin
            n_err++;
            $display("FAIL resume_first cyc %0d got stalled=%b rise=%b valid=%b half=%0d exp 0/1/0/20",
                     i, a_stalled, a_rise, a_valid, a_half);
          end
        end
        49: begin
          n_vec++;
          if (a_stalled !== 1'b0 || a_fall !== 1'b1 || a_valid !== 1'b1 || a_half !== 16'd6) begin
            n_err++;
            $display("FAIL resume_second cyc %0d got stalled=%b fall=%b valid=%b half=%0d exp 0/1/1/6",
                     i, a_stalled, a_fall, a_valid, a_half);
          end
        end
        default: ;
      endcase
      if (i == 0 || i == 5 || i == 10 || i == 15 || i == 40 || i == 46) lvl = ~lvl;
      slow_in = lvl;
      step();
    end
  endtask

  task automatic test_reset_mid();
    logic lvl = 1'b0;
    apply_reset();
    for (int i = 0; i <= 30; i++) begin
      case (i)
        11: begin
          n_vec++;
          if (a_half !== 16'd4 || a_valid !== 1'b1) begin
            n_err++;
            $display("FAIL mid_pre cyc %0d got half=%0d valid=%b exp 4/1", i, a_half, a_valid);
          end
        end
        14, 15: begin
          n_vec++;
          if (a_half !== 16'd0 || a_valid !== 1'b0 || a_fall !== 1'b0 || a_sync !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset cyc %0d got half=%0d valid=%b fall=%b sync=%b exp 0/0/0/0",
                     i, a_half, a_valid, a_fall, a_sync);
          end
        end
        19: begin
          n_vec++;
          if (a_rise !== 1'b1 || a_half !== 16'd4 || a_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_first cyc %0d got rise=%b half=%0d valid=%b exp 1/4/0",
                     i, a_rise, a_half, a_valid);
          end
        end
        22: begin
          n_vec++;
          if (a_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_wait cyc %0d got valid=%b exp 0", i, a_valid);
          end
        end
        23: begin
          n_vec++;
          if (a_fall !== 1'b1 || a_half !== 16'd4 || a_valid !== 1'b1) begin
            n_err++;
            $display("FAIL mid_second cyc %0d got fall=%b half=%0d valid=%b exp 1/4/1",
                     i, a_fall, a_half, a_valid);
          end
        end
        default: ;
      endcase
      if (i == 0 || i == 4 || i == 8 || i == 12 || i == 16 || i == 20 || i == 24) lvl = ~lvl;
      slow_in = lvl;
      reset   = (i == 13);
      step();
    end
  endtask

  task automatic test_long_periods();
    logic lvl = 1'b0;
    apply_reset();
    for (int i = 0; i <= 810; i++) begin
      if (i < 503) begin
        n_vec++;
        if (b_stalled !== 1'b0) begin
          n_err++;
          $display("FAIL long_no_stall cyc %0d got stalled=%b exp 0", i, b_stalled);
        end
      end
      case (i)
        2: begin
          n_vec++;
          if (b_sync !== 1'b1) begin
            n_err++;
            $display("FAIL long_sync cyc %0d got %b exp 1", i, b_sync);
          end
        end
        153, 303: begin
          n_vec++;
          if (b_half !== 8'd150 || b_valid !== 1'b1 || (b_fall | b_rise) !== 1'b1) begin
            n_err++;
            $display("FAIL long_150 cyc %0d got half=%0d valid=%b tick=%b exp 150/1/1",
                     i, b_half, b_valid, b_fall | b_rise);
          end
        end
        503, 552, 753: begin
          n_vec++;
          if (b_stalled !== 1'b1 || b_valid !== 1'b0) begin
            n_err++;
            $display("FAIL long_stall cyc %0d got stalled=%b valid=%b exp 1/0", i, b_stalled, b_valid);
          end
        end
        553, 803: begin
          n_vec++;
          if (b_stalled !== 1'b0 || b_half !== 8'd200 || b_valid !== 1'b0) begin
            n_err++;
            $display("FAIL long_250 cyc %0d got stalled=%b half=%0d valid=%b exp 0/200/0",
                     i, b_stalled, b_half, b_valid);
          end
        end
        default: ;
      endcase
      if (i == 0 || i == 150 || i == 300 || i == 550 || i == 800) lvl = ~lvl;
      slow_in = lvl;
      step();
    end
  endtask

  task automatic test_edge_on_saturation();
    logic lvl = 1'b0;
    apply_reset();
    for (int i = 0; i <= 45; i++) begin
      n_vec++;
      if (a_stalled !== 1'b0) begin
        n_err++;
        $display("FAIL sat_no_stall cyc %0d got stalled=%b exp 0", i, a_stalled);
      end
      if (i == 23 || i == 43) begin
        n_vec++;
        if (a_half !== 16'd20 || a_valid !== 1'b1 || (a_rise ^ a_fall) !== 1'b1) begin
          n_err++;
          $display("FAIL sat_edge cyc %0d got half=%0d valid=%b rise=%b fall=%b exp 20/1/one tick",
                   i, a_half, a_valid, a_rise, a_fall);
        end
      end
      if (i == 0 || i == 20 || i == 40) lvl = ~lvl;
      slow_in = lvl;
      step();
    end
  endtask

  initial begin
    reset   = 1'b1;
    slow_in = 1'b0;
    test_reset();
    test_toggle4();
    test_stall_resume();
    test_reset_mid();
    test_long_periods();
    test_edge_on_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
